pippo_opfwd: RTL

PIPPO_OPFWD -- requirements
Module: pippo_opfwd

---
 rtl/def_pippo.sv | 19 +
 rtl/pippo_opfwd_sel.sv | 32 +++
 rtl/pippo_opfwd.sv | 129 ++++++++++++
 3 files changed

// File: rtl/def_pippo.sv
// def_pippo: widths, FSM encoding and operand-source codes shared by the pippo operand-forwarding block.
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 32
`endif
package def_pippo;
   localparam int GPR_AW      = 5;
   localparam int STALL_CNT_W = 16;
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LDUSE = 2'd1,
      ST_WAIT  = 2'd2
   } fwd_state_e;
   typedef enum logic [1:0] {
      SRC_GPR   = 2'd0,
      SRC_EX    = 2'd1,
      SRC_WB    = 2'd2,
      SRC_WBREG = 2'd3
   } fwd_src_e;
endpackage

// File: rtl/pippo_opfwd_sel.sv
// pippo_opfwd_sel: one operand's source select, EX > WB > write-back register > GPR.
module pippo_opfwd_sel import def_pippo::*; #(
   parameter int width     = `OPERAND_WIDTH,
   parameter bit wbreg_fwd = 1'b0
) (
   input  logic              en,
   input  logic [GPR_AW-1:0] addr,
   input  logic [width-1:0]  gpr_rdata,
   input  logic              ex_wren,
   input  logic [GPR_AW-1:0] ex_addr,
   input  logic [width-1:0]  ex_result,
   input  logic              wb_wren,
   input  logic [GPR_AW-1:0] wb_addr,
   input  logic [width-1:0]  wb_data,
   input  logic              wbreg_vld,
   input  logic [GPR_AW-1:0] wbreg_addr,
   input  logic [width-1:0]  wb_fwd,
   output fwd_src_e          src,
   output logic [width-1:0]  data
);
   logic ex_hit;
   logic wb_hit;
   logic wbreg_hit;
   always_comb begin
      ex_hit    = en && ex_wren && ex_addr == addr;
      wb_hit    = en && wb_wren && wb_addr == addr;
      wbreg_hit = en && wbreg_vld && wbreg_addr == addr;
      src       = ex_hit ? SRC_EX : wb_hit ? SRC_WB : wbreg_hit ? SRC_WBREG : SRC_GPR;
      // without the write-back-register path a wbreg hit is resolved by a stall, so GPR data is passed
      data      = ex_hit ? ex_result : wb_hit ? wb_data : (wbreg_hit && wbreg_fwd) ? wb_fwd : gpr_rdata;
   end
endmodule

// File: rtl/pippo_opfwd.sv
// pippo_opfwd: ID->EX operand forwarding with load-use stall FSM and stall counter.
// Defining PIPPO_OPFWD_WBREG_EN enables forwarding from the registered write-back value (wb_fwd).
module pippo_opfwd import def_pippo::*; #(
   parameter int width = `OPERAND_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic                   id_ra_en,
   input  logic                   id_rb_en,
   input  logic [GPR_AW-1:0]      id_ra_addr,
   input  logic [GPR_AW-1:0]      id_rb_addr,
   input  logic [width-1:0]       gpr_rdata_a,
   input  logic [width-1:0]       gpr_rdata_b,
   input  logic                   ex_wren,
   input  logic [GPR_AW-1:0]      ex_addr,
   input  logic [width-1:0]       ex_result,
   input  logic                   ex_is_load,
   input  logic                   ex_result_vld,
   input  logic                   wb_wren,
   input  logic [GPR_AW-1:0]      wb_addr,
   input  logic [width-1:0]       wb_data,
   input  logic                   wb_freeze,
   input  logic [width-1:0]       wb_fwd,
   input  logic                   ex_freeze,
   output logic [width-1:0]       opa,
   output logic [width-1:0]       opb,
   output logic                   ex_op_valid,
   output logic                   id_stall,
   output logic [STALL_CNT_W-1:0] stall_cnt
);
`ifdef PIPPO_OPFWD_WBREG_EN
   localparam bit WBREG_FWD = 1'b1;
`else
   localparam bit WBREG_FWD = 1'b0;
`endif
   fwd_state_e             state_q, state_d;
   logic [GPR_AW-1:0]      wbreg_addr_q, wbreg_addr_d;
   logic                   wbreg_vld_q, wbreg_vld_d;
   logic [width-1:0]       opa_q, opa_d, opb_q, opb_d;
   logic                   ex_op_valid_q, ex_op_valid_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   wbhaz_q, wbhaz_d;
   logic                   wbreg_use, load_haz, wbreg_haz, stall;
   fwd_src_e               src_a, src_b;
   logic [width-1:0]       sel_a, sel_b;

   // the cycle after a wbreg stall the GPR holds the value, so the wbreg match is ignored
   assign wbreg_use = wbreg_vld_q && !(state_q == ST_LDUSE && wbhaz_q);
   assign load_haz  = id_valid && ex_is_load && (src_a == SRC_EX || src_b == SRC_EX);
`ifdef PIPPO_OPFWD_WBREG_EN
   assign wbreg_haz = 1'b0;
`else
   assign wbreg_haz = id_valid && (src_a == SRC_WBREG || src_b == SRC_WBREG);
`endif

   pippo_opfwd_sel #(.width(width), .wbreg_fwd(WBREG_FWD)) u_sel_a (
      .en(id_ra_en), .addr(id_ra_addr), .gpr_rdata(gpr_rdata_a),
      .ex_wren(ex_wren), .ex_addr(ex_addr), .ex_result(ex_result),
      .wb_wren(wb_wren), .wb_addr(wb_addr), .wb_data(wb_data),
      .wbreg_vld(wbreg_use), .wbreg_addr(wbreg_addr_q), .wb_fwd(wb_fwd),
      .src(src_a), .data(sel_a)
   );

   pippo_opfwd_sel #(.width(width), .wbreg_fwd(WBREG_FWD)) u_sel_b (
      .en(id_rb_en), .addr(id_rb_addr), .gpr_rdata(gpr_rdata_b),
      .ex_wren(ex_wren), .ex_addr(ex_addr), .ex_result(ex_result),
      .wb_wren(wb_wren), .wb_addr(wb_addr), .wb_data(wb_data),
      .wbreg_vld(wbreg_use), .wbreg_addr(wbreg_addr_q), .wb_fwd(wb_fwd),
      .src(src_b), .data(sel_b)
   );

   always_comb begin
      stall   = 1'b0;
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            stall   = load_haz || wbreg_haz;
            state_d = stall ? ST_LDUSE : ST_RUN;
         end
         ST_LDUSE: begin
            stall   = !wbhaz_q;
            state_d = (ex_result_vld || wbhaz_q) ? ST_RUN : ST_WAIT;
         end
         ST_WAIT: begin
            stall   = !ex_result_vld;
            state_d = ex_result_vld ? ST_RUN : ST_WAIT;
         end
         default: state_d = ST_RUN;
      endcase
      if (ex_freeze) state_d = state_q;
      wbhaz_d       = (!ex_freeze && state_q == ST_RUN) ? (wbreg_haz && !load_haz) : wbhaz_q;
      opa_d         = (ex_freeze || stall) ? opa_q : sel_a;
      opb_d         = (ex_freeze || stall) ? opb_q : sel_b;
      ex_op_valid_d = ex_freeze ? ex_op_valid_q : (id_valid && !stall);
      stall_cnt_d   = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      wbreg_addr_d  = wb_freeze ? wbreg_addr_q : wb_addr;
      wbreg_vld_d   = wb_freeze ? wbreg_vld_q : wb_wren;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         wbhaz_q       <= 1'b0;
         opa_q         <= '0;
         opb_q         <= '0;
         ex_op_valid_q <= 1'b0;
         stall_cnt_q   <= '0;
         wbreg_addr_q  <= '0;
         wbreg_vld_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wbhaz_q       <= wbhaz_d;
         opa_q         <= opa_d;
         opb_q         <= opb_d;
         ex_op_valid_q <= ex_op_valid_d;
         stall_cnt_q   <= stall_cnt_d;
         wbreg_addr_q  <= wbreg_addr_d;
         wbreg_vld_q   <= wbreg_vld_d;
      end
   end

   // id_stall is combinational, so it is masked while reset is held
   assign id_stall    = rst && stall;
   assign opa         = opa_q;
   assign opb         = opb_q;
   assign ex_op_valid = ex_op_valid_q;
   assign stall_cnt   = stall_cnt_q;
endmodule
